// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 3-stage IF/ID/EX pipeline: Mealy stall, flush, forward and hold controls.
// FSM state, statistics counters and the sticky timeout flag update on the falling clock edge.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fwd_en,
  input  logic [15:0] id_ir,
  input  logic [3:0]  ex_op,
  input  logic [1:0]  ex_wr,
  input  logic        ex_regwrite,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        ex_hold,
  output logic        fwd_a,
  output logic        fwd_b,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR  = 4'b0011, OP_SLT = 4'b0111, OP_LW  = 4'b0101,
                         OP_SW  = 4'b0110, OP_BEQ = 4'b1000, OP_BNE = 4'b1001;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_STALL    = 2'b01,
    S_MEMWAIT  = 2'b10,
    S_TIMEDOUT = 2'b11
  } state_e;

  state_e        state_q;
  logic [WW-1:0] wait_q;
  logic          mem_timeout_q;
  logic [15:0]   stall_q, flush_q;

  logic [3:0] id_op;
  logic [1:0] id_rs, id_rt;
  logic       uses_rt, dep_rs, dep_rt, ex_is_mem;
  logic       memwait_c, load_use, raw_stall, stall_issued;
  logic       unused_ir_bits;

  assign id_op = id_ir[15:12];
  assign id_rs = id_ir[11:10];
  assign id_rt = id_ir[9:8];
  assign unused_ir_bits = ^id_ir[7:0];

  assign uses_rt = (id_op == OP_ADD) || (id_op == OP_SUB) || (id_op == OP_AND) ||
                   (id_op == OP_OR)  || (id_op == OP_SLT) || (id_op == OP_SW)  ||
                   (id_op == OP_BEQ) || (id_op == OP_BNE);

  // Every opcode reads rs; $0 is hardwired, so it never creates a dependency.
  assign dep_rs = ex_regwrite && (ex_wr != 2'd0) && (ex_wr == id_rs);
  assign dep_rt = ex_regwrite && (ex_wr != 2'd0) && (ex_wr == id_rt) && uses_rt;

  assign ex_is_mem    = (ex_op == OP_LW) || (ex_op == OP_SW);
  assign memwait_c    = ex_is_mem && !mem_ready && (state_q != S_TIMEDOUT);
  assign load_use     = (ex_op == OP_LW) && (dep_rs || dep_rt);
  assign raw_stall    = !fwd_en && (ex_op != OP_LW) && (dep_rs || dep_rt);
  assign stall_issued = !memwait_c && !branch_taken && (load_use || raw_stall);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    ex_hold     = 1'b0;
    fwd_a       = 1'b0;
    fwd_b       = 1'b0;
    if (!reset_n) begin
      pc_write = 1'b1;
    end else if (memwait_c) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ex_hold    = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use || raw_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (fwd_en && (ex_op != OP_LW)) begin
      fwd_a = dep_rs;
      fwd_b = dep_rt;
    end
  end

  // The wait count reaching TIMEOUT means TIMEOUT falling edges spent in MEMWAIT.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RUN;
      wait_q        <= '0;
      mem_timeout_q <= 1'b0;
      stall_q       <= 16'd0;
      flush_q       <= 16'd0;
    end else begin
      if (!pc_write && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (ifid_flush && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
      case (state_q)
        S_RUN, S_STALL: begin
          if (memwait_c) begin
            state_q <= S_MEMWAIT;
            wait_q  <= '0;
          end else begin
            state_q <= stall_issued ? S_STALL : S_RUN;
          end
        end
        S_MEMWAIT: begin
          if (!memwait_c) begin
            state_q <= stall_issued ? S_STALL : S_RUN;
          end else if (wait_q == WAIT_LAST) begin
            state_q       <= S_TIMEDOUT;
            wait_q        <= wait_q + WW'(1);
            mem_timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table plus memory-wait, timeout, reset and load-use sequences.
module tb_pipe_hazard_ctrl;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, ANDI = 4'b0010, SLT = 4'b0111,
                         ADDI = 4'b0100, LW = 4'b0101, SW = 4'b0110, BEQ = 4'b1000;
  // {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, fwd_a, fwd_b}
  localparam logic [6:0] C_DEF = 7'b1100000, C_STL = 7'b0001000, C_HLD = 7'b0000100,
                         C_FLS = 7'b1111000, C_FA  = 7'b1100010, C_FB  = 7'b1100001,
                         C_FAB = 7'b1100011;
  localparam logic [1:0] RUN = 2'b00, STL = 2'b01, MW = 2'b10, TO = 2'b11;

  logic clock = 1'b0;
  logic reset_n, fwd_en, ex_regwrite, branch_taken, mem_ready;
  logic [15:0] id_ir;
  logic [3:0]  ex_op;
  logic [1:0]  ex_wr;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, fwd_a, fwd_b, mem_timeout;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;
  logic [6:0]  ctrl;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.TIMEOUT(8)) dut (
    .clock(clock), .reset_n(reset_n), .fwd_en(fwd_en), .id_ir(id_ir), .ex_op(ex_op),
    .ex_wr(ex_wr), .ex_regwrite(ex_regwrite), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .ex_hold(ex_hold),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, fwd_a, fwd_b};

  typedef struct {
    logic        fwd;
    logic [15:0] ir;
    logic [3:0]  op;
    logic [1:0]  wr;
    logic        rw, br, rdy;
    logic [6:0]  ctrl;
    logic [1:0]  nst;
  } vec_t;

  typedef struct packed {
    logic [6:0] ctrl;
    logic [1:0] nst;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[20];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rs, input logic [1:0] rt);
    return {op, rs, rt, 8'h00};
  endfunction

  function automatic vec_t mkv(input logic f, input logic [15:0] ir, input logic [3:0] op,
                               input logic [1:0] wr, input logic rw, input logic br, input logic rdy,
                               input logic [6:0] c, input logic [1:0] ns);
    vec_t v;
    v.fwd = f; v.ir = ir; v.op = op; v.wr = wr; v.rw = rw; v.br = br; v.rdy = rdy;
    v.ctrl = c; v.nst = ns;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    fwd_en = v.fwd; id_ir = v.ir; ex_op = v.op; ex_wr = v.wr;
    ex_regwrite = v.rw; branch_taken = v.br; mem_ready = v.rdy;
  endtask

  // Drive after the rising edge, check controls before the falling edge, check state after it.
  task automatic step(input vec_t v, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    drive(v);
    sb.push_back({v.ctrl, v.nst});
    #2;
    e = sb.pop_front();
    chk({nm, " ctrl"}, 32'(ctrl), 32'(e.ctrl));
    @(negedge clock);
    #1;
    chk({nm, " state"}, 32'(state), 32'(e.nst));
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    drive(mkv(1, 16'h0, ADD, 2'd0, 0, 0, 1, C_DEF, RUN));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  vec_t idle, lwdep;

  initial begin
    idle  = mkv(1, 16'h0, ADD, 2'd0, 0, 0, 1, C_DEF, RUN);
    lwdep = mkv(1, ins(ADD, 2'd1, 2'd1), LW, 2'd1, 1, 0, 0, C_HLD, MW);

    tbl[0]  = idle;
    tbl[1]  = mkv(1, ins(ANDI, 2'd1, 2'd2), ADDI, 2'd2, 1, 0, 1, C_FB,  RUN);
    tbl[2]  = mkv(1, ins(ANDI, 2'd1, 2'd2), ADDI, 2'd1, 1, 0, 1, C_FA,  RUN);
    tbl[3]  = mkv(1, ins(ADD,  2'd1, 2'd1), SUB,  2'd1, 1, 0, 1, C_FAB, RUN);
    tbl[4]  = mkv(1, ins(ADDI, 2'd2, 2'd1), ADD,  2'd1, 1, 0, 1, C_DEF, RUN);
    tbl[5]  = mkv(1, ins(ADD,  2'd0, 2'd0), ADD,  2'd0, 1, 0, 1, C_DEF, RUN);
    tbl[6]  = mkv(1, ins(ADD,  2'd1, 2'd1), ADD,  2'd1, 0, 0, 1, C_DEF, RUN);
    tbl[7]  = mkv(0, ins(ADD,  2'd1, 2'd2), ADD,  2'd1, 1, 0, 1, C_STL, STL);
    tbl[8]  = mkv(0, ins(ADD,  2'd2, 2'd3), ADD,  2'd1, 1, 0, 1, C_DEF, RUN);
    tbl[9]  = mkv(1, ins(SW,   2'd2, 2'd1), LW,   2'd1, 1, 0, 1, C_STL, STL);
    tbl[10] = mkv(1, ins(ADDI, 2'd2, 2'd1), LW,   2'd1, 1, 0, 1, C_DEF, RUN);
    tbl[11] = mkv(1, ins(ADD,  2'd1, 2'd2), BEQ,  2'd0, 0, 1, 1, C_FLS, RUN);
    tbl[12] = mkv(1, ins(ADD,  2'd1, 2'd2), SW,   2'd0, 0, 0, 0, C_HLD, MW);
    tbl[13] = mkv(1, ins(ADD,  2'd1, 2'd2), SW,   2'd0, 0, 0, 1, C_DEF, RUN);
    tbl[14] = mkv(1, ins(ADD,  2'd1, 2'd2), LW,   2'd1, 1, 0, 0, C_HLD, MW);
    tbl[15] = mkv(1, ins(ADD,  2'd1, 2'd2), LW,   2'd1, 1, 0, 1, C_STL, STL);
    tbl[16] = mkv(1, ins(BEQ,  2'd3, 2'd2), ADDI, 2'd2, 1, 0, 1, C_FB,  RUN);
    tbl[17] = mkv(1, ins(SLT,  2'd3, 2'd0), ADD,  2'd3, 1, 0, 1, C_FA,  RUN);
    tbl[18] = mkv(0, ins(SW,   2'd0, 2'd2), SUB,  2'd2, 1, 0, 1, C_STL, STL);
    tbl[19] = mkv(1, ins(ADD,  2'd1, 2'd2), BEQ,  2'd0, 0, 1, 1, C_FLS, RUN);

    // Reset state, with a pending memory wait presented to the inputs.
    reset_n = 1'b0;
    drive(idle);
    @(posedge clock);
    #1;
    drive(mkv(1, 16'h0, SW, 2'd0, 0, 0, 0, C_DEF, RUN));
    #2;
    chk("reset ctrl", 32'(ctrl), 32'(C_DEF));
    @(negedge clock);
    #1;
    chk("reset state", 32'(state), 32'(RUN));
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset flush_cnt", 32'(flush_cnt), 32'd0);
    chk("reset mem_timeout", 32'(mem_timeout), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(idle);

    for (int i = 0; i < 20; i++) step(tbl[i], $sformatf("vec%0d", i));
    chk("table stall_cnt", 32'(stall_cnt), 32'd6);
    chk("table flush_cnt", 32'(flush_cnt), 32'd2);

    // sw with mem_ready low for three cycles.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(mkv(1, 16'h0, SW, 2'd0, 0, 0, 0, C_HLD, MW), $sformatf("sw wait%0d", i));
    step(mkv(1, 16'h0, SW, 2'd0, 0, 0, 1, C_DEF, RUN), "sw done");
    chk("sw stall_cnt", 32'(stall_cnt), 32'd3);
    chk("sw flush_cnt", 32'(flush_cnt), 32'd0);

    // lw with mem_ready stuck low: eight falling edges in MEMWAIT, then TIMEDOUT.
    lwdep.ir = 16'h0;
    step(lwdep, "to enter");
    for (int i = 0; i < 7; i++) step(lwdep, $sformatf("to wait%0d", i));
    chk("to flag early", 32'(mem_timeout), 32'd0);
    lwdep.nst = TO;
    step(lwdep, "to last");
    chk("to flag set", 32'(mem_timeout), 32'd1);
    lwdep.ctrl = C_DEF;
    lwdep.nst  = RUN;
    step(lwdep, "to release");
    step(idle, "to idle");
    chk("to flag sticky", 32'(mem_timeout), 32'd1);
    chk("to stall_cnt", 32'(stall_cnt), 32'd12);

    // Reset asserted mid-MEMWAIT.
    step(mkv(1, 16'h0, SW, 2'd0, 0, 0, 0, C_HLD, MW), "rst mw");
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst mw state", 32'(state), 32'(RUN));
    chk("rst mw ctrl", 32'(ctrl), 32'(C_DEF));
    chk("rst mw flag", 32'(mem_timeout), 32'd0);
    chk("rst mw stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(idle);

    // lw $1 then add $2,$1,$1: one stall, then the bubble clears the dependency.
    step(mkv(1, ins(ADD, 2'd1, 2'd1), LW,  2'd1, 1, 0, 1, C_STL, STL), "lu stall");
    step(mkv(1, ins(ADD, 2'd1, 2'd1), ADD, 2'd0, 0, 0, 1, C_DEF, RUN), "lu bubble");
    chk("lu stall_cnt", 32'(stall_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
